// File: rtl/alu8_pkg.sv
// Shared opcodes, widths, FSM encoding and the reference ALU operation for the
// alu8 / alu8_arbiter slice.
package alu8_pkg;

  localparam int DW = 8;
  localparam int RW = 9;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_NAND = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ADD  = 3'd6;
  localparam logic [2:0] OP_SUB  = 3'd7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Operands are zero-extended to RW bits, so inverting ops set bit 8 and
  // ADD/SUB expose carry/borrow there.
  function automatic logic [RW-1:0] alu_op(input logic [2:0] sel,
                                           input logic [DW-1:0] a,
                                           input logic [DW-1:0] b);
    logic [RW-1:0] xa;
    logic [RW-1:0] xb;
    logic [RW-1:0] res;
    xa = {1'b0, a};
    xb = {1'b0, b};
    case (sel)
      OP_AND:  res = xa & xb;
      OP_NAND: res = ~(xa & xb);
      OP_OR:   res = xa | xb;
      OP_NOR:  res = ~(xa | xb);
      OP_XOR:  res = xa ^ xb;
      OP_XNOR: res = ~(xa ^ xb);
      OP_ADD:  res = xa + xb;
      OP_SUB:  res = xa - xb;
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu8.sv
// Registered 8-bit ALU with a LAT-deep result pipeline and a 9-bit result.
module alu8 import alu8_pkg::*; #(
  parameter int unsigned LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [2:0]    sel,
  output logic [RW-1:0] result
);

  logic [RW-1:0] pipe_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= alu_op(sel, a, b);
      for (int i = 1; i < LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign result = pipe_q[LAT-1];

endmodule

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant; the priority pointer lives in the parent.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant,
  output logic       gnt_id
);

  always_comb begin
    gnt_id = 1'b0;
    grant  = 2'b00;
    if (valid == 2'b11) begin
      gnt_id = prio;
    end else begin
      gnt_id = valid[1];
    end
    if (valid != 2'b00) begin
      grant = gnt_id ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/alu8_arbiter.sv
// Shares one registered alu8 between two valid/ready requesters, one operation
// at a time, returning an ID-tagged result on a held response port.
module alu8_arbiter import alu8_pkg::*; #(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [2:0]    req0_sel,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [2:0]    req1_sel,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [RW-1:0] rsp_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_sel,
  input  logic [RW-1:0] alu_result,
  output logic          busy
);

  localparam logic [1:0] CNT_LOAD = 2'(ALU_LAT - 1);

  arb_state_t    state_q, state_d;
  logic          prio_q;
  logic          id_q;
  logic [DW-1:0] a_q;
  logic [DW-1:0] b_q;
  logic [2:0]    sel_q;
  logic [RW-1:0] res_q;
  logic [1:0]    cnt_q;

  logic [1:0]    req_valid;
  logic [1:0]    grant;
  logic          gnt_id;
  logic          accept;

  assign req_valid = {req1_valid, req0_valid};

  rr_arb2 u_arb (
    .valid  (req_valid),
    .prio   (prio_q),
    .grant  (grant),
    .gnt_id (gnt_id)
  );

  assign accept = (state_q == IDLE) && (req_valid != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (cnt_q == 2'd0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state_q == IDLE) && grant[0];
    req1_ready = (state_q == IDLE) && grant[1];
    rsp_valid  = (state_q == RESP);
    busy       = (state_q != IDLE);
  end

  // Latched request, wait counter and captured result.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q <= 1'b0;
      id_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sel_q  <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        id_q   <= gnt_id;
        a_q    <= gnt_id ? req1_a : req0_a;
        b_q    <= gnt_id ? req1_b : req0_b;
        sel_q  <= gnt_id ? req1_sel : req0_sel;
        prio_q <= ~gnt_id;
      end
      if (state_q == ISSUE) begin
        cnt_q <= CNT_LOAD;
      end else if ((state_q == WAIT) && (cnt_q != 2'd0)) begin
        cnt_q <= cnt_q - 2'd1;
      end
      if ((state_q == WAIT) && (cnt_q == 2'd0)) begin
        res_q <= alu_result;
      end
    end
  end

  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_sel    = sel_q;

endmodule

// File: tb/tb_alu8_arbiter.sv
// Scoreboard bench: two arbiters (ALU_LAT 1 and 4), each with a real alu8,
// checked against a plain-arithmetic model of grants, results and latency.
module tb_alu8_arbiter;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
  } op_t;

  typedef struct {
    logic        id;
    logic [8:0]  res;
    int unsigned acc;
    bit          seen;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst        [2];
  logic       v          [2][2];
  logic       rdy        [2][2];
  logic [7:0] a          [2][2];
  logic [7:0] b          [2][2];
  logic [2:0] sel        [2][2];
  logic       rsp_valid  [2];
  logic       rsp_ready  [2];
  logic       rsp_id     [2];
  logic [8:0] rsp_result [2];
  logic [7:0] alu_a      [2];
  logic [7:0] alu_b      [2];
  logic [2:0] alu_sel    [2];
  logic [8:0] alu_res    [2];
  logic       busy       [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned L = (g == 0) ? 1 : 4;
    alu8_arbiter #(.ALU_LAT(L)) u_dut (
      .clk        (clk),
      .rst        (rst[g]),
      .req0_valid (v[g][0]),
      .req0_ready (rdy[g][0]),
      .req0_a     (a[g][0]),
      .req0_b     (b[g][0]),
      .req0_sel   (sel[g][0]),
      .req1_valid (v[g][1]),
      .req1_ready (rdy[g][1]),
      .req1_a     (a[g][1]),
      .req1_b     (b[g][1]),
      .req1_sel   (sel[g][1]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_ready  (rsp_ready[g]),
      .rsp_id     (rsp_id[g]),
      .rsp_result (rsp_result[g]),
      .alu_a      (alu_a[g]),
      .alu_b      (alu_b[g]),
      .alu_sel    (alu_sel[g]),
      .alu_result (alu_res[g]),
      .busy       (busy[g])
    );
    alu8 #(.LAT(L)) u_alu (
      .clk    (clk),
      .rst    (rst[g]),
      .a      (alu_a[g]),
      .b      (alu_b[g]),
      .sel    (alu_sel[g]),
      .result (alu_res[g])
    );
  end

  op_t         opq [2][2][$];
  exp_t        sb [2][$];
  bit          acc_flag [2][2];
  bit          prio_m [2];
  int          rdy_mode [2];   // 0 hold off, 1 always ready, 2 random
  bit          gate_rand [2];
  bit          rst_seen [2];
  int          vectors = 0;
  int          miscompares = 0;

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference ALU: 9-bit wrap of plain integer arithmetic on unsigned operands.
  function automatic logic [8:0] ref_alu(logic [2:0] s, logic [7:0] x, logic [7:0] y);
    int xi;
    int yi;
    int r;
    xi = int'(x);
    yi = int'(y);
    case (s)
      3'd0:    r = xi & yi;
      3'd1:    r = ~(xi & yi);
      3'd2:    r = xi | yi;
      3'd3:    r = ~(xi | yi);
      3'd4:    r = xi ^ yi;
      3'd5:    r = ~(xi ^ yi);
      3'd6:    r = xi + yi;
      default: r = xi - yi;
    endcase
    return r[8:0];
  endfunction

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Driver: present queued ops, hold them until accepted, drive rsp_ready.
  always begin
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 2; n++) begin
        if (acc_flag[d][n]) begin
          acc_flag[d][n] = 1'b0;
          if (opq[d][n].size() != 0) void'(opq[d][n].pop_front());
          v[d][n] = 1'b0;
        end
        if (!v[d][n] && (opq[d][n].size() != 0) &&
            (!gate_rand[d] || ($urandom_range(0, 1) == 1))) begin
          v[d][n]   = 1'b1;
          a[d][n]   = opq[d][n][0].a;
          b[d][n]   = opq[d][n][0].b;
          sel[d][n] = opq[d][n][0].sel;
        end
      end
      case (rdy_mode[d])
        0:       rsp_ready[d] = 1'b0;
        1:       rsp_ready[d] = 1'b1;
        default: rsp_ready[d] = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Grant checker: round-robin rule, push expected response on accept.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      logic    eid;
      if (rst[d]) begin
        prio_m[d] = 1'b0;
        continue;
      end
      if (rdy[d][0] || rdy[d][1]) begin
        if (!(v[d][0] || v[d][1])) begin
          chk(1'b0, "ready_without_valid", {rdy[d][1], rdy[d][0]}, 0);
          continue;
        end
        eid = (v[d][0] && v[d][1]) ? prio_m[d] : !v[d][0];
        chk({rdy[d][1], rdy[d][0]} == (eid ? 2'b10 : 2'b01), "grant",
            {rdy[d][1], rdy[d][0]}, eid ? 2 : 1);
        chk(sb[d].size() == 0, "ready_while_busy", sb[d].size(), 0);
        sb[d].push_back('{id: eid, res: ref_alu(sel[d][eid], a[d][eid], b[d][eid]),
                          acc: cyc, seen: 1'b0});
        prio_m[d]        = !eid;
        acc_flag[d][eid] = 1'b1;
      end
    end
  end

  // Response monitor: latency, ID, result, hold stability, busy, reset values.
  always begin
    @(negedge clk);
    #2;
    for (int d = 0; d < 2; d++) begin
      bit exp_busy;
      if (rst[d]) begin
        sb[d].delete();
        rst_seen[d] = 1'b1;
        continue;
      end
      if (rst_seen[d]) begin
        rst_seen[d] = 1'b0;
        chk(rsp_valid[d] == 1'b0, "rst_rsp_valid", rsp_valid[d], 0);
        chk(rsp_id[d] == 1'b0, "rst_rsp_id", rsp_id[d], 0);
        chk(rsp_result[d] == 9'h000, "rst_rsp_result", rsp_result[d], 0);
        chk({alu_a[d], alu_b[d], alu_sel[d]} == 19'h0, "rst_alu_operands",
            {alu_a[d], alu_b[d], alu_sel[d]}, 0);
      end
      if (v[d][0] || v[d][1]) chk(sb[d].size() != 0, "missed_grant", 0, 1);
      exp_busy = (sb[d].size() != 0) && (sb[d][0].acc < cyc);
      chk(busy[d] == exp_busy, "busy", busy[d], exp_busy);
      if (rsp_valid[d]) begin
        if (sb[d].size() == 0) begin
          chk(1'b0, "unexpected_rsp", rsp_result[d], 0);
        end else begin
          if (!sb[d][0].seen) begin
            chk(cyc == sb[d][0].acc + 2 + lat_of(d), "rsp_latency",
                cyc - sb[d][0].acc, 2 + lat_of(d));
            sb[d][0].seen = 1'b1;
          end
          chk(rsp_id[d] == sb[d][0].id, "rsp_id", rsp_id[d], sb[d][0].id);
          chk(rsp_result[d] == sb[d][0].res, "rsp_result", rsp_result[d], sb[d][0].res);
          if (rsp_ready[d]) void'(sb[d].pop_front());
        end
      end else if ((sb[d].size() != 0) && (cyc == sb[d][0].acc + 2 + lat_of(d))) begin
        chk(1'b0, "rsp_late", 0, 1);
      end
    end
  end

  task automatic drain(input int d);
    int n = 0;
    while (((opq[d][0].size() != 0) || (opq[d][1].size() != 0) || (sb[d].size() != 0) ||
            v[d][0] || v[d][1]) && (n < 4000)) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) chk(1'b0, "drain_timeout", n, 4000);
    repeat (2) @(negedge clk);
    #3;
  endtask

  task automatic pulse_reset(input int d);
    @(posedge clk);
    #1 rst[d] = 1'b1;
    @(posedge clk);
    #1 rst[d] = 1'b0;
    @(negedge clk);
    #3;
  endtask

  initial begin
    int unsigned acc;
    int n;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      rdy_mode[d] = 1;
      rsp_ready[d] = 1'b1;
      gate_rand[d] = 1'b0;
      for (int k = 0; k < 2; k++) begin
        v[d][k] = 1'b0;
        a[d][k] = '0;
        b[d][k] = '0;
        sel[d][k] = '0;
      end
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    @(negedge clk);
    #3;

    // Single ADD with carry, then SUB with borrow from requester 1.
    opq[0][0].push_back('{8'hFF, 8'h01, 3'd6});
    drain(0);
    opq[0][1].push_back('{8'h05, 8'h07, 3'd7});
    drain(0);

    // Contention right after reset: grants must alternate starting at 0.
    pulse_reset(0);
    for (int k = 0; k < 2; k++) begin
      opq[0][0].push_back('{8'hF0, 8'h3C, 3'd0});
      opq[0][1].push_back('{8'hF0, 8'h3C, 3'd4});
    end
    drain(0);

    // Backpressure: hold RESP for 5 cycles with another request waiting.
    rdy_mode[0] = 0;
    opq[0][0].push_back('{8'h12, 8'h34, 3'd2});
    n = 0;
    while (!rsp_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk(1'b0, "bp_rsp_timeout", n, 50);
    #3;
    opq[0][1].push_back('{8'h9C, 8'h0F, 3'd5});
    repeat (5) @(posedge clk);
    #1 rdy_mode[0] = 1;
    drain(0);

    // Random traffic with random valid gaps and random backpressure.
    gate_rand[0] = 1'b1;
    rdy_mode[0] = 2;
    for (int k = 0; k < 30; k++) begin
      opq[0][0].push_back('{8'($urandom), 8'($urandom), 3'($urandom)});
      opq[0][1].push_back('{8'($urandom), 8'($urandom), 3'($urandom)});
    end
    drain(0);

    // ALU_LAT=4: sweep every opcode.
    for (int s = 0; s < 8; s++) opq[1][0].push_back('{8'hA5, 8'h5A, 3'(s)});
    drain(1);

    // Reset in the second WAIT cycle drops the op; next requests start at prio 0.
    opq[1][1].push_back('{8'h33, 8'h44, 3'd6});
    n = 0;
    while (sb[1].size() == 0 && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (n >= 50) chk(1'b0, "rst_accept_timeout", n, 50);
    acc = (sb[1].size() != 0) ? sb[1][0].acc : cyc;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (cyc != acc + 3 && n < 50);
    rst[1] = 1'b1;
    @(posedge clk);
    #1 rst[1] = 1'b0;
    repeat (10) @(negedge clk);
    #3;
    opq[1][0].push_back('{8'h80, 8'h80, 3'd6});
    opq[1][1].push_back('{8'h01, 8'h02, 3'd7});
    drain(1);

    gate_rand[1] = 1'b1;
    rdy_mode[1] = 2;
    for (int k = 0; k < 10; k++) begin
      opq[1][0].push_back('{8'($urandom), 8'($urandom), 3'($urandom)});
      opq[1][1].push_back('{8'($urandom), 8'($urandom), 3'($urandom)});
    end
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
